// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: access-size and fault-code encodings shared by the data memory
package mips_mem_pkg;
  typedef enum logic [1:0] {SIZE_B = 2'b00, SIZE_H = 2'b01, SIZE_W = 2'b10, SIZE_RSV = 2'b11} size_e;
  typedef enum logic [1:0] {FLT_OK = 2'b00, FLT_MISAL = 2'b01, FLT_OOR = 2'b10, FLT_SIZE = 2'b11} fault_e;
endpackage

// File: rtl/mips_byte_lane_ram.sv
// mips_byte_lane_ram: DEPTH_WORDS x 4 x 8 RAM, per-lane write enable, registered read
// Ports: clk; we_i lane write enables (lane l = bits [8l+7:8l]); re_i read enable;
//        addr_i word index; wdata_i lane data; rdata_o registered read word (holds when re_i=0)
module mips_byte_lane_ram #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic [3:0]    we_i,
  input  logic          re_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);
  for (genvar l = 0; l < 4; l++) begin : g_lane
    logic [7:0] mem [DEPTH_WORDS];
    logic [7:0] rd_q;
    always_ff @(posedge clk) begin
      if (we_i[l]) mem[addr_i] <= wdata_i[8*l +: 8];
      if (re_i) rd_q <= mem[addr_i];
    end
    assign rdata_o[8*l +: 8] = rd_q;
  end
endmodule

// File: rtl/mips_data_mem_pipe.sv
// mips_data_mem_pipe: MIPS data memory with valid/ready request and response channels
// Ports: clk, rst_n (sync, active-low); request req_valid/req_ready/req_write/req_size/
//        req_signed/req_addr/req_wdata; response resp_valid/resp_ready/resp_rdata/resp_fault
module mips_data_mem_pipe
  import mips_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter bit BIG_ENDIAN  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_fault
);
  localparam int AW = $clog2(DEPTH_WORDS * 4);
  size_e       sz, size_q;
  fault_e      flt, fault_q;
  logic        acc, mis, valid_q, valid_d, load_q, sgn_q;
  logic [1:0]  lane, lane_q;
  logic [3:0]  be, we;
  logic [31:0] wd, rd, ext;
  logic [7:0]  b;
  logic [15:0] h;
  assign sz        = size_e'(req_size);
  assign req_ready = !valid_q || resp_ready;
  assign acc       = req_valid && req_ready;
  assign mis       = (sz == SIZE_H && req_addr[0]) || (sz == SIZE_W && req_addr[1:0] != 2'b00);
  assign flt       = sz == SIZE_RSV ? FLT_SIZE : req_addr >= 32'(4 * DEPTH_WORDS) ? FLT_OOR : mis ? FLT_MISAL : FLT_OK;
  // Physical lane of the addressed byte; for halfwords lane[1] picks the upper or lower half in either endianness
  assign lane      = BIG_ENDIAN ? ~req_addr[1:0] : req_addr[1:0];
  assign be        = sz == SIZE_W ? 4'hF : sz == SIZE_H ? (lane[1] ? 4'hC : 4'h3) : 4'b0001 << lane;
  // A store coinciding with reset is dropped along with any pending response
  assign we        = {4{acc && rst_n && req_write && flt == FLT_OK}} & be;
  assign wd        = sz == SIZE_W ? req_wdata : sz == SIZE_H ? {2{req_wdata[15:0]}} : {4{req_wdata[7:0]}};
  assign valid_d   = acc || (valid_q && !resp_ready);
  mips_byte_lane_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clk    (clk),
    .we_i   (we),
    .re_i   (acc && !req_write),
    .addr_i (req_addr[AW-1:2]),
    .wdata_i(wd),
    .rdata_o(rd)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      fault_q <= FLT_OK;
      load_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (acc) begin
        fault_q <= flt;
        load_q  <= !req_write && flt == FLT_OK;
        size_q  <= sz;
        sgn_q   <= req_signed;
        lane_q  <= lane;
      end
    end
  end
  // The RAM read register plus the captured lane/size metadata form the response register;
  // extraction and extension are pure functions of that registered state
  assign b          = rd[{lane_q, 3'b000} +: 8];
  assign h          = lane_q[1] ? rd[31:16] : rd[15:0];
  assign ext        = size_q == SIZE_B ? {{24{sgn_q && b[7]}}, b} : size_q == SIZE_H ? {{16{sgn_q && h[15]}}, h} : rd;
  assign resp_rdata = load_q ? ext : 32'h0;
  assign resp_fault = fault_q;
  assign resp_valid = valid_q;
endmodule

// File: tb/tb_mips_data_mem_pipe.sv
// tb_mips_data_mem_pipe: directed and randomized checks of mips_data_mem_pipe against a byte-array model
module tb_mips_data_mem_pipe;
  logic        clk = 0, rst_n = 0, req_valid = 0, req_write = 0, req_signed = 0, resp_ready = 1;
  logic [1:0]  req_size = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic        req_ready, resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_fault;
  int          total = 0, passed = 0;
  logic [7:0]  m [1024];
  logic        ev = 0;
  logic [31:0] er = 0;
  logic [1:0]  ef = 0;

  mips_data_mem_pipe #(.DEPTH_WORDS(256), .BIG_ENDIAN(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_fault(resp_fault)
  );

  always #5 clk = ~clk;

  function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", n, act, exp);
  endfunction

  // Reference: big-endian byte-addressed memory, one response slot
  always @(posedge clk) begin
    logic [9:0] a;
    logic [7:0] v;
    logic [15:0] hv;
    if (!rst_n) begin
      ev = 0; er = 0; ef = 0;
    end else if (req_valid && (!ev || resp_ready)) begin
      a  = req_addr[9:0];
      ef = req_size == 3 ? 2'd3 : req_addr >= 1024 ? 2'd2 :
           ((req_size == 1 && req_addr[0]) || (req_size == 2 && req_addr[1:0] != 0)) ? 2'd1 : 2'd0;
      er = 0;
      if (ef == 0 && req_write) begin
        if (req_size == 0) m[a] = req_wdata[7:0];
        else if (req_size == 1) begin m[a] = req_wdata[15:8]; m[a+1] = req_wdata[7:0]; end
        else begin m[a] = req_wdata[31:24]; m[a+1] = req_wdata[23:16]; m[a+2] = req_wdata[15:8]; m[a+3] = req_wdata[7:0]; end
      end else if (ef == 0) begin
        v  = m[a];
        hv = {m[a], m[a+1]};
        if (req_size == 0) er = req_signed && v[7] ? 32'hFFFFFF00 | v : {24'h0, v};
        else if (req_size == 1) er = req_signed && hv[15] ? 32'hFFFF0000 | hv : {16'h0, hv};
        else er = {m[a], m[a+1], m[a+2], m[a+3]};
      end
      ev = 1;
    end else if (resp_ready) ev = 0;
  end

  always @(negedge clk) begin
    chk("resp_valid", resp_valid, ev);
    chk("req_ready", req_ready, !ev || resp_ready);
    chk("resp_rdata", resp_rdata, er);
    chk("resp_fault", resp_fault, ef);
  end

  task automatic drive(logic w, logic [1:0] sz, logic sg, logic [31:0] ad, logic [31:0] wd);
    req_valid = 1; req_write = w; req_size = sz; req_signed = sg; req_addr = ad; req_wdata = wd;
  endtask

  task automatic op(logic w, logic [1:0] sz, logic sg, logic [31:0] ad, logic [31:0] wd);
    drive(w, sz, sg, ad, wd);
    @(posedge clk); #2;
    req_valid = 0;
  endtask

  initial begin
    logic [1:0] sz;
    logic [31:0] ad;
    @(posedge clk); @(posedge clk); #2;
    chk("reset valid", resp_valid, 0);
    chk("reset rdata", resp_rdata, 0);
    chk("reset fault", resp_fault, 0);
    rst_n = 1;
    op(1, 2, 1, 0, 32'h11223344); op(0, 2, 1, 0, 0);
    chk("t1 word", resp_rdata, 32'h11223344); chk("t1 fault", resp_fault, 0);
    op(1, 1, 0, 6, 32'h0000EF12); op(0, 1, 0, 6, 0);
    chk("t2 lhu", resp_rdata, 32'h0000EF12);
    op(0, 1, 1, 6, 0);
    chk("t2 lh", resp_rdata, 32'hFFFFEF12);
    op(1, 0, 0, 6, 32'h34); op(0, 1, 0, 6, 0);
    chk("t3 lhu", resp_rdata, 32'h00003412);
    op(0, 0, 1, 3, 0);
    chk("t4 lb pos", resp_rdata, 32'h00000044);
    op(1, 0, 0, 3, 32'h80); op(0, 0, 1, 3, 0);
    chk("t4 lb neg", resp_rdata, 32'hFFFFFF80);
    op(0, 0, 0, 3, 0);
    chk("t4 lbu", resp_rdata, 32'h00000080);
    op(0, 2, 0, 2, 0);
    chk("t5 misal fault", resp_fault, 1); chk("t5 misal rdata", resp_rdata, 0);
    op(1, 2, 0, 32'h400, 32'hDEADBEEF);
    chk("t5 oor fault", resp_fault, 2);
    op(0, 3, 0, 0, 0);
    chk("t5 size fault", resp_fault, 3);
    op(0, 2, 0, 0, 0);
    chk("t5 reload", resp_rdata, 32'h11223380);
    resp_ready = 0;
    drive(0, 2, 0, 0, 0);
    @(posedge clk); #2;
    drive(0, 1, 0, 6, 0);
    repeat (3) begin
      @(posedge clk); #2;
      chk("t6 stall ready", req_ready, 0);
      chk("t6 held valid", resp_valid, 1);
      chk("t6 held rdata", resp_rdata, 32'h11223380);
    end
    resp_ready = 1;
    @(posedge clk); #2;
    chk("t6 queued", resp_rdata, 32'h00003412);
    drive(1, 0, 0, 7, 32'hAA);
    rst_n = 0;
    @(posedge clk); #2;
    chk("t6 reset valid", resp_valid, 0);
    rst_n = 1;
    op(0, 1, 0, 6, 0);
    chk("t6 store dropped", resp_rdata, 32'h00003412);
    for (int i = 0; i < 256; i++) op(1, 2, 0, i * 4, $urandom);
    for (int i = 0; i < 3000; i++) begin
      rst_n      = $urandom_range(0, 99) != 0;
      resp_ready = $urandom_range(0, 3) != 0;
      sz = $urandom_range(0, 15) == 0 ? 2'd3 : 2'($urandom_range(0, 2));
      ad = $urandom_range(0, 9) == 0 ? 32'h400 + $urandom_range(0, 2000) : $urandom_range(0, 1023);
      if ($urandom_range(0, 9) < 7) ad = sz == 2 ? ad & ~32'd3 : sz == 1 ? ad & ~32'd1 : ad;
      req_valid = $urandom_range(0, 4) != 0;
      req_write = $urandom_range(0, 1);
      req_size = sz; req_addr = ad; req_signed = $urandom_range(0, 1); req_wdata = $urandom;
      @(posedge clk); #2;
    end
    req_valid = 0; rst_n = 1; resp_ready = 1;
    repeat (3) @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
